// File: rtl/dino_obs_pkg.sv
// rtl/dino_obs_pkg.sv - shared constants, state encoding and type mapping for the obstacle scheduler
// Purpose: obstacle type codes, LFSR tap mask and default seed, scheduler FSM states,
//          and the raw-to-obstacle type mapping used at capture time.
package dino_obs_pkg;

  localparam logic [1:0] OBS_SMALL = 2'd0;
  localparam logic [1:0] OBS_LARGE = 2'd1;
  localparam logic [1:0] OBS_BIRD  = 2'd2;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SPAWN = 2'd3
  } state_e;

  // Raw code 3 folds onto the small cactus; birds are suppressed at the lowest difficulty.
  function automatic logic [1:0] map_obs_type(input logic [1:0] raw, input logic [1:0] speed);
    logic [1:0] t;
    t = raw;
    if (raw == 2'd3) begin
      t = OBS_SMALL;
    end else if (raw == OBS_BIRD && speed == 2'd0) begin
      t = OBS_LARGE;
    end
    return t;
  endfunction

endpackage

// File: rtl/dino_down_counter.sv
// rtl/dino_down_counter.sv - loadable T-flip-flop down counter for obstacle gaps
// Purpose: counts down once per clock, wrapping from 0 to all-ones; a load overrides the count.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset, count returns to 0
//   load_en_i   - load strobe
//   load_data_i - value to load
//   count_o     - current count
module dino_down_counter #(
  parameter int unsigned BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en_i,
  input  logic [BITS-1:0] load_data_i,
  output logic [BITS-1:0] count_o
);

  logic [BITS-1:0] count_q;
  logic [BITS-1:0] count_d;
  logic [BITS-1:0] toggle;

  // A bit toggles on decrement when every lower bit is zero (borrow ripple).
  always_comb begin
    toggle[0] = 1'b1;
    for (int i = 1; i < int'(BITS); i++) begin
      toggle[i] = toggle[i-1] & ~count_q[i-1];
    end
  end

  assign count_d = load_en_i ? load_data_i : (count_q ^ toggle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/obs_lfsr16.sv
// rtl/obs_lfsr16.sv - free-running 16-bit Fibonacci LFSR
// Purpose: pseudo-random source for gap length and obstacle type.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset, loads SEED (0 replaced by 1)
//   lfsr_o - current 16-bit register state
module obs_lfsr16
  import dino_obs_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  // An all-zero state would lock the register up, so it is never used as a seed.
  localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  assign feedback = ^(lfsr_q & LFSR_TAPS);
  assign lfsr_d   = {lfsr_q[14:0], feedback};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - decides when and which obstacle appears in the dino game
// Purpose: picks a pseudo-random gap and obstacle type, loads the gap into the external
//          down counter and pulses spawn when the count reaches zero.
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   game_run_i      - level: high while the game runs, low halts scheduling
//   speed_lvl_i     - difficulty, shortens the random part of the gap
//   cnt_value_i     - current down-counter value
//   cnt_load_en_o   - load strobe to the down counter
//   cnt_data_o      - gap value to load
//   spawn_o         - one-cycle "place obstacle now" pulse
//   obs_type_o      - obstacle type, valid with spawn_o and held until the next spawn
//   spawn_count_o   - spawns in the current run, saturating at 255
module obstacle_scheduler
  import dino_obs_pkg::*;
#(
  parameter int unsigned     BITS    = 9,
  parameter logic [BITS-1:0] MIN_GAP = 9'd64,
  parameter logic [15:0]     SEED    = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            game_run_i,
  input  logic [1:0]      speed_lvl_i,
  input  logic [BITS-1:0] cnt_value_i,
  output logic            cnt_load_en_o,
  output logic [BITS-1:0] cnt_data_o,
  output logic            spawn_o,
  output logic [1:0]      obs_type_o,
  output logic [7:0]      spawn_count_o
);

  localparam int unsigned SUM_W = BITS + 1;

  logic [15:0] lfsr;
  logic        unused_lfsr_bits;

  obs_lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr_o(lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:10];

  // Gap arithmetic is one bit wider than the counter so overflow can be clamped.
  logic [7:0]      rnd_part;
  logic [BITS:0]   gap_sum;
  logic [BITS-1:0] gap_val;
  logic [1:0]      type_val;

  assign rnd_part = lfsr[7:0] >> speed_lvl_i;
  assign gap_sum  = {1'b0, MIN_GAP} + SUM_W'(rnd_part);
  assign gap_val  = gap_sum[BITS] ? '1 : gap_sum[BITS-1:0];
  assign type_val = map_obs_type(lfsr[9:8], speed_lvl_i);

  state_e          state_q, state_d;
  logic [BITS-1:0] cnt_data_q, cnt_data_d;
  logic [1:0]      obs_type_q, obs_type_d;
  logic [7:0]      spawn_count_q, spawn_count_d;
  logic            capture;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (game_run_i) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_WAIT;
      // Leave on the zero cycle; the wrapped all-ones value is replaced by the reload in SPAWN.
      ST_WAIT:  if (cnt_value_i == '0) state_d = ST_SPAWN;
      ST_SPAWN: state_d = ST_WAIT;
      default:  state_d = ST_IDLE;
    endcase
    if (!game_run_i) begin
      state_d = ST_IDLE;
    end
  end

  // Gap and type are sampled from the pre-advance LFSR on the edge entering LOAD or SPAWN.
  assign capture    = (state_d == ST_LOAD) || (state_d == ST_SPAWN);
  assign cnt_data_d = capture ? gap_val : cnt_data_q;
  assign obs_type_d = capture ? type_val : obs_type_q;

  always_comb begin
    spawn_count_d = spawn_count_q;
    if (state_q == ST_IDLE && state_d == ST_LOAD) begin
      spawn_count_d = 8'd0;
    end else if (state_d == ST_SPAWN && spawn_count_q != 8'hFF) begin
      spawn_count_d = spawn_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_data_q    <= '0;
      obs_type_q    <= OBS_SMALL;
      spawn_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_data_q    <= cnt_data_d;
      obs_type_q    <= obs_type_d;
      spawn_count_q <= spawn_count_d;
    end
  end

  assign cnt_load_en_o = (state_q == ST_LOAD) || (state_q == ST_SPAWN);
  assign spawn_o       = (state_q == ST_SPAWN);
  assign cnt_data_o    = cnt_data_q;
  assign obs_type_o    = obs_type_q;
  assign spawn_count_o = spawn_count_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - self-checking bench for obstacle_scheduler with its down counter
module tb_obstacle_scheduler;
  import dino_obs_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] speed;
  logic       game_run    [NI];
  logic [8:0] cnt_value   [NI];
  logic       load_en     [NI];
  logic [8:0] cnt_data    [NI];
  logic       spawn       [NI];
  logic [1:0] obs_type    [NI];
  logic [7:0] spawn_count [NI];
  logic [15:0] lfsr_obs   [NI];
  logic [1:0] state_obs   [NI];

  // 0: default build, 1: MIN_GAP=1, 2: MIN_GAP=400 with a seed whose low byte is 0xFF
  for (genvar g = 0; g < NI; g++) begin : g_dut
    obstacle_scheduler #(
      .BITS   (9),
      .MIN_GAP(g == 0 ? 9'd64 : (g == 1 ? 9'd1 : 9'd400)),
      .SEED   (g == 2 ? 16'h03FF : 16'hACE1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .game_run_i   (game_run[g]),
      .speed_lvl_i  (speed),
      .cnt_value_i  (cnt_value[g]),
      .cnt_load_en_o(load_en[g]),
      .cnt_data_o   (cnt_data[g]),
      .spawn_o      (spawn[g]),
      .obs_type_o   (obs_type[g]),
      .spawn_count_o(spawn_count[g])
    );
    dino_down_counter #(.BITS(9)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en_i  (load_en[g]),
      .load_data_i(cnt_data[g]),
      .count_o    (cnt_value[g])
    );
    assign lfsr_obs[g]  = u_dut.lfsr;
    assign state_obs[g] = u_dut.state_q;
  end

  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int min_gap_of(input int i);
    return (i == 0) ? 64 : ((i == 1) ? 1 : 400);
  endfunction

  function automatic logic [15:0] seed_of(input int i);
    return (i == 2) ? 16'h03FF : 16'hACE1;
  endfunction

  function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int n);
    logic [15:0] s;
    s = seed;
    for (int j = 0; j < n; j++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic int gap_of(input int mg, input logic [15:0] l, input int spd);
    int g;
    g = mg + (int'(l[7:0]) >> spd);
    return (g > 511) ? 511 : g;
  endfunction

  function automatic int type_of(input logic [15:0] l, input int spd);
    int r;
    r = int'(l[9:8]);
    if (r == 3) return 0;
    if (r == 2 && spd == 0) return 1;
    return r;
  endfunction

  typedef struct {
    int edge_no;
    int data;
    int otyp;
  } exp_t;
  exp_t sb[$];

  // Predict the spawn that follows a load of gap d at edge from_edge, with speed spd at its capture.
  task automatic push_next(input int i, input int from_edge, input int d, input int spd);
    exp_t e;
    logic [15:0] l;
    e.edge_no = from_edge + d + 2;
    l = lfsr_at(seed_of(i), e.edge_no - 1);
    e.data = gap_of(min_gap_of(i), l, spd);
    e.otyp = type_of(l, spd);
    sb.push_back(e);
  endtask

  task automatic wait_spawn(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (spawn[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_spawn(input int i, input int next_spd, input int budget);
    exp_t e;
    bit ok;
    e = sb.pop_front();
    wait_spawn(i, budget, ok);
    check("spawn_seen", 32'(ok), 1);
    check("spawn_edge", edges, e.edge_no);
    check("spawn_cnt_data", 32'(cnt_data[i]), e.data);
    check("spawn_obs_type", 32'(obs_type[i]), e.otyp);
    check("spawn_reload", 32'(load_en[i]), 1);
    push_next(i, e.edge_no, e.data, next_spd);
  endtask

  initial begin
    int halt_spawns;
    int nseen;
    int d;
    bit ok;

    rst_n = 1'b0;
    speed = 2'd0;
    foreach (game_run[k]) game_run[k] = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_load_en", 32'(load_en[0]), 0);
    check("rst_spawn", 32'(spawn[0]), 0);
    check("rst_spawn_count", 32'(spawn_count[0]), 0);
    check("rst_cnt_data", 32'(cnt_data[0]), 0);
    check("rst_obs_type", 32'(obs_type[0]), 0);
    check("rst_lfsr", 32'(lfsr_obs[0]), 32'h0000ACE1);
    check("rst_lfsr_b", 32'(lfsr_obs[2]), 32'h000003FF);

    // First load at speed 0, then 50 spawns against the reference model
    rst_n = 1'b1;
    game_run[0] = 1'b1;
    @(negedge clk);
    check("first_load_en", 32'(load_en[0]), 1);
    check("first_load_edge", edges, 1);
    check("first_cnt_data", 32'(cnt_data[0]), 32'h121);
    sb.delete();
    push_next(0, 1, 289, 0);
    check_spawn(0, 0, 600);
    check("first_spawn_edge", edges, 292);
    check("first_spawn_count", 32'(spawn_count[0]), 1);
    for (int n = 2; n <= 50; n++) begin
      @(negedge clk);
      check("pulse_width", 32'(spawn[0]), 0);
      check_spawn(0, 0, 600);
      check("spawn_count", 32'(spawn_count[0]), n);
      check("type_no_bird_speed0", 32'(obs_type[0] < 2'd2), 1);
    end

    // Halt mid-WAIT, then resume
    repeat (5) @(negedge clk);
    game_run[0] = 1'b0;
    @(negedge clk);
    check("halt_idle", 32'(state_obs[0]), 32'(ST_IDLE));
    check("halt_load_en", 32'(load_en[0]), 0);
    check("halt_count_held", 32'(spawn_count[0]), 50);
    halt_spawns = 0;
    repeat (400) begin
      @(negedge clk);
      if (spawn[0]) halt_spawns++;
    end
    check("halt_no_spawn", halt_spawns, 0);
    game_run[0] = 1'b1;
    @(negedge clk);
    check("resume_load_en", 32'(load_en[0]), 1);
    check("resume_count_clear", 32'(spawn_count[0]), 0);
    d = gap_of(64, lfsr_at(16'hACE1, edges - 1), 0);
    check("resume_cnt_data", 32'(cnt_data[0]), d);
    sb.delete();
    push_next(0, edges, d, 0);
    check_spawn(0, 0, 600);
    check("resume_spawn_count", 32'(spawn_count[0]), 1);

    // Difficulty: speed 2 from reset, then a speed change while a gap is loaded
    game_run[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    speed = 2'd2;
    game_run[0] = 1'b1;
    @(negedge clk);
    check("diff_load_edge", edges, 1);
    check("diff_cnt_data", 32'(cnt_data[0]), 120);
    sb.delete();
    push_next(0, 1, 120, 2);
    check_spawn(0, 1, 600);
    check("diff_spawn_edge", edges, 123);
    @(negedge clk);
    speed = 2'd1;
    check_spawn(0, 1, 600);
    check_spawn(0, 1, 600);
    game_run[0] = 1'b0;

    // Saturation with MIN_GAP = 1
    speed = 2'd3;
    game_run[1] = 1'b1;
    nseen = 0;
    for (int n = 1; n <= 300; n++) begin
      wait_spawn(1, 300, ok);
      if (ok) nseen++;
      if (n == 255) check("sat_at_255", 32'(spawn_count[1]), 255);
    end
    check("sat_spawns_seen", nseen, 300);
    check("sat_held", 32'(spawn_count[1]), 255);

    // Asynchronous reset in the middle of a SPAWN cycle
    wait_spawn(1, 300, ok);
    check("pre_reset_spawn", 32'(ok), 1);
    rst_n = 1'b0;
    #1;
    check("arst_spawn", 32'(spawn[1]), 0);
    check("arst_load_en", 32'(load_en[1]), 0);
    check("arst_spawn_count", 32'(spawn_count[1]), 0);
    check("arst_cnt_data", 32'(cnt_data[1]), 0);
    check("arst_obs_type", 32'(obs_type[1]), 0);
    check("arst_lfsr", 32'(lfsr_obs[1]), 32'h0000ACE1);
    game_run[1] = 1'b0;

    // Boundary gap: 400 + 255 clamps to 511
    speed = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    game_run[2] = 1'b1;
    @(negedge clk);
    check("bound_load_edge", edges, 1);
    check("bound_cnt_data", 32'(cnt_data[2]), 511);
    sb.delete();
    push_next(2, 1, 511, 0);
    check_spawn(2, 0, 600);
    check("bound_spawn_edge", edges, 514);
    check_spawn(2, 0, 600);
    game_run[2] = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
